load_store_unit: RTL and testbench

Load/store unit between the execute stage and the byte-addressed data memory. Accepts one memory request per handshake and checks funct3, alignment and address range. Drives the memory's write-enable, read-enable, byte-enable, address and store-data inputs, and holds them through the memory's one-cycle registered read. Returns sign- or zero-extended load data, or an error code, through a valid/ready response port.

---
 rtl/load_store_unit.sv | 151 +++++++++++++++
 tb/tb_load_store_unit.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one request per handshake, classifies it, drives the
// data memory through its one-cycle registered read and returns an extended result.
module load_store_unit #(
    parameter int ADDR_BITWIDTH = 10
) (
    input  logic                     LSU_Clk,
    input  logic                     LSU_Reset_n,
    input  logic                     LSU_Req_Valid,
    output logic                     LSU_Req_Ready,
    input  logic                     LSU_Req_Store,
    input  logic [2:0]               LSU_Req_Funct3,
    input  logic [31:0]              LSU_Req_Addr,
    input  logic [31:0]              LSU_Req_Wdata,
    output logic                     LSU_Resp_Valid,
    input  logic                     LSU_Resp_Ready,
    output logic [31:0]              LSU_Resp_Rdata,
    output logic [1:0]               LSU_Resp_Err,
    output logic                     LSU_Mem_We,
    output logic                     LSU_Mem_Re,
    output logic [3:0]               LSU_Mem_Byteenable,
    output logic [ADDR_BITWIDTH-1:0] LSU_Mem_Address,
    output logic [31:0]              LSU_Mem_Data_In,
    input  logic [31:0]              LSU_Mem_Data_Out
);

    typedef enum logic [1:0] {IDLE, ACCESS, LOAD_DATA, RESP} state_t;

    state_t                   state_reg;
    state_t                   state_next;
    logic                     store_reg;
    logic [2:0]               funct3_reg;
    logic [ADDR_BITWIDTH-1:0] addr_reg;
    logic [31:0]              wdata_reg;
    logic [1:0]               err_reg;
    logic [31:0]              rdata_reg;

    logic                     req_fire;
    logic                     resp_fire;
    logic                     illegal;
    logic                     misaligned;
    logic                     fault;
    logic [1:0]               req_err;
    logic [31:0]              load_ext;

    assign req_fire  = LSU_Req_Valid && (state_reg == IDLE);
    assign resp_fire = LSU_Resp_Ready && (state_reg == RESP);

    // Classification of the incoming request; priority illegal > misaligned > fault.
    always_comb begin
        if (LSU_Req_Store) begin
            illegal = (LSU_Req_Funct3 > 3'd2);
        end else begin
            illegal = (LSU_Req_Funct3 == 3'b011) || (LSU_Req_Funct3[2:1] == 2'b11);
        end
        misaligned = ((LSU_Req_Funct3[1:0] == 2'b01) && LSU_Req_Addr[0]) ||
                     ((LSU_Req_Funct3[1:0] == 2'b10) && (LSU_Req_Addr[1:0] != 2'b00));
        fault = |LSU_Req_Addr[31:ADDR_BITWIDTH];
        if (illegal) begin
            req_err = 2'b11;
        end else if (misaligned) begin
            req_err = 2'b01;
        end else if (fault) begin
            req_err = 2'b10;
        end else begin
            req_err = 2'b00;
        end
    end

    always_ff @(posedge LSU_Clk or negedge LSU_Reset_n) begin
        if (!LSU_Reset_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (req_fire) begin
                    state_next = (req_err != 2'b00) ? RESP : ACCESS;
                end
            end
            ACCESS:    state_next = store_reg ? RESP : LOAD_DATA;
            LOAD_DATA: state_next = RESP;
            RESP: begin
                if (resp_fire) begin
                    state_next = IDLE;
                end
            end
            default:   state_next = IDLE;
        endcase
    end

    // Memory returns right-aligned zero-extended data; only signed loads need work.
    always_comb begin
        case (funct3_reg)
            3'b000:  load_ext = {{24{LSU_Mem_Data_Out[7]}}, LSU_Mem_Data_Out[7:0]};
            3'b001:  load_ext = {{16{LSU_Mem_Data_Out[15]}}, LSU_Mem_Data_Out[15:0]};
            default: load_ext = LSU_Mem_Data_Out;
        endcase
    end

    always_ff @(posedge LSU_Clk or negedge LSU_Reset_n) begin
        if (!LSU_Reset_n) begin
            store_reg  <= 1'b0;
            funct3_reg <= 3'b000;
            addr_reg   <= '0;
            wdata_reg  <= 32'h0;
            err_reg    <= 2'b00;
            rdata_reg  <= 32'h0;
        end else begin
            if (req_fire) begin
                store_reg  <= LSU_Req_Store;
                funct3_reg <= LSU_Req_Funct3;
                addr_reg   <= LSU_Req_Addr[ADDR_BITWIDTH-1:0];
                wdata_reg  <= LSU_Req_Wdata;
                err_reg    <= req_err;
                rdata_reg  <= 32'h0;
            end else if (state_reg == LOAD_DATA) begin
                rdata_reg  <= load_ext;
            end
        end
    end

    // Memory drive is purely a function of state so a reset removes We at once.
    always_comb begin
        LSU_Req_Ready      = (state_reg == IDLE);
        LSU_Resp_Valid     = (state_reg == RESP);
        LSU_Resp_Rdata     = rdata_reg;
        LSU_Resp_Err       = err_reg;
        LSU_Mem_We         = 1'b0;
        LSU_Mem_Re         = 1'b0;
        LSU_Mem_Byteenable = 4'b1111;
        LSU_Mem_Address    = '0;
        LSU_Mem_Data_In    = 32'h0;
        if ((state_reg == ACCESS) || (state_reg == LOAD_DATA)) begin
            LSU_Mem_We      = (state_reg == ACCESS) && store_reg;
            LSU_Mem_Re      = !store_reg;
            LSU_Mem_Address = addr_reg;
            LSU_Mem_Data_In = wdata_reg;
            case (funct3_reg[1:0])
                2'b00:   LSU_Mem_Byteenable = 4'b0001;
                2'b01:   LSU_Mem_Byteenable = 4'b0011;
                default: LSU_Mem_Byteenable = 4'b1111;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: byte memory with registered read, table vectors,
// hand-written corner sequences and randomized requests against a byte-array model.
module tb_load_store_unit;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic [1:0]  resp_err;
    logic        mem_we;
    logic        mem_re;
    logic [3:0]  mem_be;
    logic [9:0]  mem_addr;
    logic [31:0] mem_din;
    logic [31:0] mem_dout;

    int passed = 0;
    int total  = 0;

    load_store_unit #(.ADDR_BITWIDTH(10)) dut (
        .LSU_Clk            (clk),
        .LSU_Reset_n        (rst_n),
        .LSU_Req_Valid      (req_valid),
        .LSU_Req_Ready      (req_ready),
        .LSU_Req_Store      (req_store),
        .LSU_Req_Funct3     (req_funct3),
        .LSU_Req_Addr       (req_addr),
        .LSU_Req_Wdata      (req_wdata),
        .LSU_Resp_Valid     (resp_valid),
        .LSU_Resp_Ready     (resp_ready),
        .LSU_Resp_Rdata     (resp_rdata),
        .LSU_Resp_Err       (resp_err),
        .LSU_Mem_We         (mem_we),
        .LSU_Mem_Re         (mem_re),
        .LSU_Mem_Byteenable (mem_be),
        .LSU_Mem_Address    (mem_addr),
        .LSU_Mem_Data_In    (mem_din),
        .LSU_Mem_Data_Out   (mem_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Data memory: byte writes, registered read, output muxed by current byte-enable.
    logic [7:0]  mem [0:1023];
    logic [31:0] rd_q;
    bit          mem_cleared;
    always @(posedge clk) begin
        if (!mem_cleared) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 8'h00;
            mem_cleared <= 1'b1;
        end else begin
            if (mem_we) begin
                for (int b = 0; b < 4; b++)
                    if (mem_be[b]) mem[(int'(mem_addr) + b) % 1024] <= mem_din[8*b +: 8];
            end
            if (mem_re) begin
                rd_q <= {mem[(int'(mem_addr) + 3) % 1024], mem[(int'(mem_addr) + 2) % 1024],
                         mem[(int'(mem_addr) + 1) % 1024], mem[int'(mem_addr)]};
            end
        end
    end
    assign mem_dout = mem_re ? (rd_q & {{8{mem_be[3]}}, {8{mem_be[2]}}, {8{mem_be[1]}}, {8{mem_be[0]}}}) : 32'h0;

    int         we_pulses = 0;
    int         re_cycles = 0;
    logic [3:0] we_be;
    logic [9:0] we_addr;
    always @(posedge clk) begin
        if (mem_we) begin
            we_pulses <= we_pulses + 1;
            we_be     <= mem_be;
            we_addr   <= mem_addr;
        end
        if (mem_re) re_cycles <= re_cycles + 1;
    end

    // Reference model: plain byte array, rules applied arithmetically.
    logic [7:0] ref_mem [0:1023];

    function automatic void model(input logic st, input logic [2:0] f3, input logic [31:0] a,
                                  input logic [31:0] wd, output logic [31:0] rd, output logic [1:0] er);
        int     size;
        bit     legal;
        longint v;
        size  = 1 << f3[1:0];
        legal = st ? (f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        rd    = 32'h0;
        if (!legal)                 er = 2'b11;
        else if (a % size != 0)     er = 2'b01;
        else if (a >= 32'd1024)     er = 2'b10;
        else begin
            er = 2'b00;
            if (st) begin
                for (int i = 0; i < size; i++) ref_mem[int'(a) + i] = wd[8*i +: 8];
            end else begin
                v = 0;
                for (int i = 0; i < size; i++) v += longint'(ref_mem[int'(a) + i]) << (8*i);
                if (!f3[2] && size < 4 && v >= (longint'(1) << (8*size - 1)))
                    v -= (longint'(1) << (8*size));
                rd = v[31:0];
            end
        end
    endfunction

    function automatic int exp_lat(input logic st, input logic [1:0] er);
        if (er != 2'b00) return 0;
        return st ? 1 : 2;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
    endtask

    typedef struct {
        logic [31:0] rd;
        logic [1:0]  er;
        int          lat;
        int          wed;
        int          red;
        logic        drv_re;
        logic [3:0]  drv_be;
        logic [9:0]  drv_addr;
    } res_t;

    // One full request/response with Resp_Ready high; lat = negedges after accept until valid.
    task automatic do_req(input logic st, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, output res_t r);
        int n;
        int w0;
        int r0;
        @(negedge clk);
        req_valid = 1'b1; req_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
        n = 0;
        while (!req_ready && n < 100) begin @(negedge clk); n++; end
        w0 = we_pulses; r0 = re_cycles;
        @(posedge clk);
        @(negedge clk);
        req_valid  = 1'b0;
        r.drv_re   = mem_re;
        r.drv_be   = mem_be;
        r.drv_addr = mem_addr;
        r.lat      = 0;
        while (!resp_valid && r.lat < 20) begin @(negedge clk); r.lat++; end
        r.rd  = resp_rdata;
        r.er  = resp_err;
        r.wed = we_pulses - w0;
        r.red = re_cycles - r0;
        @(posedge clk);
    endtask

    typedef struct {
        string       nm;
        logic        st;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] rd;
        logic [1:0]  er;
    } vec_t;

    vec_t        vecs [13];
    res_t        r;
    logic [31:0] m_rd;
    logic [1:0]  m_er;
    logic        st;
    logic [2:0]  f3;
    logic [31:0] a;
    int          wait_n;

    initial begin
        vecs[0]  = '{"sw_dead",    1'b1, 3'b010, 32'h10,  32'hDEADBEEF, 32'h0,        2'b00};
        vecs[1]  = '{"lw_dead",    1'b0, 3'b010, 32'h10,  32'h0,        32'hDEADBEEF, 2'b00};
        vecs[2]  = '{"sb_80",      1'b1, 3'b000, 32'h13,  32'h80,       32'h0,        2'b00};
        vecs[3]  = '{"lb_13",      1'b0, 3'b000, 32'h13,  32'h0,        32'hFFFFFF80, 2'b00};
        vecs[4]  = '{"lbu_13",     1'b0, 3'b100, 32'h13,  32'h0,        32'h00000080, 2'b00};
        vecs[5]  = '{"lw_after_sb",1'b0, 3'b010, 32'h10,  32'h0,        32'h80ADBEEF, 2'b00};
        vecs[6]  = '{"lh_12",      1'b0, 3'b001, 32'h12,  32'h0,        32'hFFFF80AD, 2'b00};
        vecs[7]  = '{"lhu_12",     1'b0, 3'b101, 32'h12,  32'h0,        32'h000080AD, 2'b00};
        vecs[8]  = '{"sh_mis",     1'b1, 3'b001, 32'h11,  32'h5555,     32'h0,        2'b01};
        vecs[9]  = '{"lw_still",   1'b0, 3'b010, 32'h10,  32'h0,        32'h80ADBEEF, 2'b00};
        vecs[10] = '{"lw_fault",   1'b0, 3'b010, 32'h400, 32'h0,        32'h0,        2'b10};
        vecs[11] = '{"ld_f3_011",  1'b0, 3'b011, 32'h0,   32'h0,        32'h0,        2'b11};
        vecs[12] = '{"st_f3_100",  1'b1, 3'b100, 32'h3,   32'h77,       32'h0,        2'b11};

        for (int i = 0; i < 1024; i++) ref_mem[i] = 8'h00;
        rst_n = 1'b0; req_valid = 1'b0; req_store = 1'b0; req_funct3 = 3'b000;
        req_addr = 32'h0; req_wdata = 32'h0; resp_ready = 1'b1;

        repeat (2) @(negedge clk);
        chk("rst_req_ready",  {31'h0, req_ready},  32'h1);
        chk("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
        chk("rst_rdata",      resp_rdata,          32'h0);
        chk("rst_err",        {30'h0, resp_err},   32'h0);
        chk("rst_we_re",      {30'h0, mem_we, mem_re}, 32'h0);
        chk("rst_be",         {28'h0, mem_be},     32'hF);
        chk("rst_addr_din",   {22'h0, mem_addr} | mem_din, 32'h0);
        rst_n = 1'b1;

        for (int i = 0; i < 13; i++) begin
            model(vecs[i].st, vecs[i].f3, vecs[i].a, vecs[i].wd, m_rd, m_er);
            do_req(vecs[i].st, vecs[i].f3, vecs[i].a, vecs[i].wd, r);
            $display("vec %0s: st=%0d f3=%0d addr=0x%0h rdata=0x%0h err=%0d lat=%0d",
                     vecs[i].nm, vecs[i].st, vecs[i].f3, vecs[i].a, r.rd, r.er, r.lat);
            chk({vecs[i].nm, "_rdata"}, r.rd, vecs[i].rd);
            chk({vecs[i].nm, "_err"}, {30'h0, r.er}, {30'h0, vecs[i].er});
            chk({vecs[i].nm, "_model"}, {r.er, r.rd[29:0]} ^ {30'h0, r.rd[31:30]}, {m_er, m_rd[29:0]} ^ {30'h0, m_rd[31:30]});
            chk({vecs[i].nm, "_lat"}, r.lat, exp_lat(vecs[i].st, vecs[i].er));
            chk({vecs[i].nm, "_we_pulses"}, r.wed, (vecs[i].st && vecs[i].er == 2'b00) ? 1 : 0);
            chk({vecs[i].nm, "_re_cycles"}, r.red, (!vecs[i].st && vecs[i].er == 2'b00) ? 2 : 0);
            if (vecs[i].er == 2'b00) begin
                chk({vecs[i].nm, "_drv_addr"}, {22'h0, r.drv_addr}, vecs[i].a);
                chk({vecs[i].nm, "_drv_be"}, {28'h0, r.drv_be}, (1 << (1 << vecs[i].f3[1:0])) - 1);
                chk({vecs[i].nm, "_drv_re"}, {31'h0, r.drv_re}, {31'h0, !vecs[i].st});
                if (vecs[i].st) begin
                    chk({vecs[i].nm, "_we_be"}, {28'h0, we_be}, (1 << (1 << vecs[i].f3[1:0])) - 1);
                    chk({vecs[i].nm, "_we_addr"}, {22'h0, we_addr}, vecs[i].a);
                end
            end
        end

        // Response back-pressure with a second request held by the requester.
        @(negedge clk);
        req_valid = 1'b1; req_store = 1'b0; req_funct3 = 3'b010; req_addr = 32'h10;
        @(posedge clk);
        @(negedge clk);
        resp_ready = 1'b0;
        req_funct3 = 3'b100; req_addr = 32'h13;
        wait_n = 0;
        while (!resp_valid && wait_n < 20) begin @(negedge clk); wait_n++; end
        chk("bp_lat", wait_n, 2);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            $display("bp cycle %0d: valid=%0d rdata=0x%0h err=%0d req_ready=%0d",
                     k, resp_valid, resp_rdata, resp_err, req_ready);
            chk("bp_valid", {31'h0, resp_valid}, 32'h1);
            chk("bp_rdata", resp_rdata, 32'h80ADBEEF);
            chk("bp_err_ready", {29'h0, resp_err, req_ready}, 32'h0);
        end
        resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("bp_after_hs", {30'h0, req_ready, resp_valid}, 32'h2);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        chk("bp_second_accepted", {31'h0, req_ready}, 32'h0);
        wait_n = 0;
        while (!resp_valid && wait_n < 20) begin @(negedge clk); wait_n++; end
        chk("bp_second_rdata", resp_rdata, 32'h00000080);
        @(posedge clk);

        // Reset in the middle of a store's ACCESS cycle.
        model(1'b1, 3'b010, 32'h20, 32'hCAFEF00D, m_rd, m_er);
        do_req(1'b1, 3'b010, 32'h20, 32'hCAFEF00D, r);
        chk("pre_sw_err", {30'h0, r.er}, 32'h0);
        @(negedge clk);
        req_valid = 1'b1; req_store = 1'b1; req_funct3 = 3'b010; req_addr = 32'h20;
        req_wdata = 32'h12345678;
        @(posedge clk);
        #2;
        req_valid = 1'b0;
        chk("rstmid_we_before", {31'h0, mem_we}, 32'h1);
        rst_n = 1'b0;
        #1;
        $display("reset mid-store: we=%0d req_ready=%0d resp_valid=%0d be=0x%0h addr=0x%0h",
                 mem_we, req_ready, resp_valid, mem_be, mem_addr);
        chk("rstmid_we", {31'h0, mem_we}, 32'h0);
        chk("rstmid_ready_valid", {30'h0, req_ready, resp_valid}, 32'h2);
        chk("rstmid_be_addr", {18'h0, mem_be, mem_addr}, 32'h3C00);
        chk("rstmid_din_rdata", mem_din | resp_rdata, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        model(1'b0, 3'b010, 32'h20, 32'h0, m_rd, m_er);
        do_req(1'b0, 3'b010, 32'h20, 32'h0, r);
        $display("lw after aborted store: rdata=0x%0h err=%0d", r.rd, r.er);
        chk("rstmid_prior", r.rd, 32'hCAFEF00D);
        chk("rstmid_model", r.rd, m_rd);

        // Randomized traffic against the reference model.
        for (int n = 0; n < 250; n++) begin
            st = 1'($urandom_range(0, 1));
            f3 = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 7))
                                            : (st ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 5)));
            a  = 32'($urandom_range(0, 1023));
            if ($urandom_range(0, 3) != 0) a = a & ~((32'd1 << f3[1:0]) - 1);
            if ($urandom_range(0, 9) == 0) a = a | (32'd1 << $urandom_range(10, 31));
            model(st, f3, a, $urandom, m_rd, m_er);
            // Re-run the store data through the model with the same value the DUT sees.
            req_wdata = 32'h0;
            if (st) begin
                m_rd = $urandom;
                model(st, f3, a, m_rd, m_rd, m_er);
                do_req(st, f3, a, ref_wd_last(a, f3), r);
            end else begin
                do_req(st, f3, a, 32'h0, r);
            end
            $display("rnd %0d: st=%0d f3=%0d addr=0x%0h rdata=0x%0h/0x%0h err=%0d/%0d lat=%0d",
                     n, st, f3, a, r.rd, m_rd, r.er, m_er, r.lat);
            chk("rnd_rdata", r.rd, m_rd);
            chk("rnd_err", {30'h0, r.er}, {30'h0, m_er});
            chk("rnd_lat", r.lat, exp_lat(st, m_er));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    // Recovers the word the model just stored so the DUT receives identical store data.
    function automatic logic [31:0] ref_wd_last(input logic [31:0] a, input logic [2:0] f3);
        logic [31:0] w;
        int          size;
        w    = 32'h0;
        size = 1 << f3[1:0];
        if (a < 32'd1024 && size <= 4 && a % size == 0) begin
            for (int i = 0; i < size; i++) w[8*i +: 8] = ref_mem[int'(a) + i];
        end
        return w;
    endfunction

endmodule
